// File: rtl/switch_debounce_sync.sv
// Slide-switch conditioner: per-bit 2-FF synchroniser followed by a tick-based
// stability debouncer, producing a clean vector and one-cycle change pulses.
module switch_debounce_sync #(
  parameter int unsigned WIDTH        = 18,
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned STABLE_TICKS = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_debounced,
  output logic [WIDTH-1:0] sw_changed,
  output logic             any_changed
);

  localparam int unsigned TCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W  = $clog2(STABLE_TICKS + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_TICKS - 1);

  logic [WIDTH-1:0]            sync1;
  logic [WIDTH-1:0]            sync2;
  logic [TCNT_W-1:0]           tcnt;
  logic                        tick;
  logic [WIDTH-1:0][CNT_W-1:0] cnt;

  logic [WIDTH-1:0][CNT_W-1:0] cnt_next;
  logic [WIDTH-1:0]            deb_next;
  logic [WIDTH-1:0]            chg_next;

  // Per-bit stability counting; any return to the accepted value restarts the count.
  always_comb begin
    cnt_next = cnt;
    deb_next = sw_debounced;
    chg_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2[i] == sw_debounced[i]) begin
        cnt_next[i] = '0;
      end else if (tick && (cnt[i] == CNT_LAST)) begin
        deb_next[i] = sync2[i];
        chg_next[i] = 1'b1;
        cnt_next[i] = '0;
      end else if (tick) begin
        cnt_next[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  // Synchroniser, sample-tick divider and debounced state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1        <= '0;
      sync2        <= '0;
      tcnt         <= '0;
      tick         <= 1'b0;
      cnt          <= '0;
      sw_debounced <= '0;
      sw_changed   <= '0;
      any_changed  <= 1'b0;
    end else begin
      sync1        <= sw_raw;
      sync2        <= sync1;
      tcnt         <= (tcnt == TCNT_LAST) ? '0 : tcnt + TCNT_W'(1);
      tick         <= (tcnt == TCNT_LAST);
      cnt          <= cnt_next;
      sw_debounced <= deb_next;
      sw_changed   <= chg_next;
      any_changed  <= |chg_next;
    end
  end

endmodule

// File: tb/tb_switch_debounce_sync.sv
// Bench for switch_debounce_sync: a reference model based on mismatch-run start
// times and the sample-tick schedule, checked every cycle, plus directed scenarios.
module tb_switch_debounce_sync;

  localparam int unsigned WIDTH        = 18;
  localparam int unsigned TICK_DIV     = 4;
  localparam int unsigned STABLE_TICKS = 3;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] sw_raw = '0;
  logic [WIDTH-1:0] sw_debounced;
  logic [WIDTH-1:0] sw_changed;
  logic             any_changed;

  switch_debounce_sync #(
    .WIDTH       (WIDTH),
    .TICK_DIV    (TICK_DIV),
    .STABLE_TICKS(STABLE_TICKS)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sw_raw      (sw_raw),
    .sw_debounced(sw_debounced),
    .sw_changed  (sw_changed),
    .any_changed (any_changed)
  );

  always #5 clk = ~clk;

  // Reference model: edges are numbered from reset release; a tick is consumed
  // at edge x when x-1 is a positive multiple of TICK_DIV. Raw input reaches the
  // debouncer two edges after it is sampled.
  int               edge_n = 0;
  logic [WIDTH-1:0] raw_hist1 = '0;
  logic [WIDTH-1:0] raw_hist2 = '0;
  logic [WIDTH-1:0] seen;
  logic [WIDTH-1:0] m_deb = '0;
  logic [WIDTH-1:0] m_chg = '0;
  int               run_start [WIDTH];

  function automatic bit tick_at(int x);
    return ((x - 1) >= int'(TICK_DIV)) && (((x - 1) % int'(TICK_DIV)) == 0);
  endfunction

  function automatic int ticks_in(int s, int e);
    int n = 0;
    for (int x = s; x <= e; x++) if (tick_at(x)) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      edge_n    = 0;
      raw_hist1 = '0;
      raw_hist2 = '0;
      m_deb     = '0;
      m_chg     = '0;
      for (int i = 0; i < WIDTH; i++) run_start[i] = 0;
    end else begin
      edge_n++;
      seen      = raw_hist2;
      raw_hist2 = raw_hist1;
      raw_hist1 = sw_raw;
      m_chg     = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (seen[i] == m_deb[i]) begin
          run_start[i] = 0;
        end else begin
          if (run_start[i] == 0) run_start[i] = edge_n;
          if (tick_at(edge_n) && ticks_in(run_start[i], edge_n) >= int'(STABLE_TICKS)) begin
            m_deb[i]     = seen[i];
            m_chg[i]     = 1'b1;
            run_start[i] = 0;
          end
        end
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance past the edge, then compare outputs against the model.
  task automatic cycle();
    @(posedge clk);
    #1;
    chk("debounced", sw_debounced, m_deb);
    chk("changed", sw_changed, m_chg);
    chk("any_changed", WIDTH'(any_changed), WIDTH'(|m_chg));
  endtask

  // Run n cycles, tallying cycles with a pulse under mask and any_changed pulses.
  task automatic run(input int n, input logic [WIDTH-1:0] mask,
                     output int pulses, output int any_pulses,
                     output int first, output logic [WIDTH-1:0] first_vec);
    pulses = 0; any_pulses = 0; first = -1; first_vec = '0;
    for (int i = 1; i <= n; i++) begin
      cycle();
      if (any_changed) any_pulses++;
      if ((sw_changed & mask) != '0) begin
        pulses++;
        if (first < 0) begin
          first     = i;
          first_vec = sw_changed;
        end
      end
    end
  endtask

  initial begin
    int p, ap, f;
    logic [WIDTH-1:0] v;

    // Reset state
    cycle();
    cycle();
    chk("rst_deb", sw_debounced, '0);
    chk("rst_chg", sw_changed, '0);
    reset_n = 1'b1;
    run(3, '1, p, ap, f, v);
    chk("idle_no_pulse", WIDTH'(p), '0);

    // 1: single bit held high; sampled on the first run cycle
    sw_raw = 18'h00001;
    run(20, 18'h00001, p, ap, f, v);
    chk("t1_latency", WIDTH'(((f - 1) >= 11) && ((f - 1) <= 14)), WIDTH'(1));
    chk("t1_latency_exact", WIDTH'(f - 1), WIDTH'(13));
    chk("t1_pulses", WIDTH'(p), WIDTH'(1));
    chk("t1_any_pulses", WIDTH'(ap), WIDTH'(1));
    chk("t1_value", sw_debounced, 18'h00001);

    // 2: 6-cycle glitch on bit 5 must be rejected
    sw_raw = 18'h00021;
    run(6, 18'h00020, p, ap, f, v);
    sw_raw = 18'h00001;
    run(20, 18'h00020, p, ap, f, v);
    chk("t2_no_pulse", WIDTH'(p + ap), '0);
    chk("t2_value", sw_debounced, 18'h00001);

    // 3: bounce bit 17 every 3 cycles for 30 cycles, then settle high
    for (int s = 0; s < 10; s++) begin
      sw_raw[17] = ~s[0];
      run(3, 18'h20000, p, ap, f, v);
      chk("t3_bounce_no_pulse", WIDTH'(p), '0);
    end
    sw_raw[17] = 1'b1;
    run(20, 18'h20000, p, ap, f, v);
    chk("t3_pulses", WIDTH'(p), WIDTH'(1));
    chk("t3_latency", WIDTH'((f > 0) && ((f - 1) <= 14)), WIDTH'(1));
    chk("t3_value", sw_debounced, 18'h20001);

    // 4: all bits rise together, then fall together
    sw_raw = '0;
    run(20, '1, p, ap, f, v);
    chk("t4_clear", sw_debounced, '0);
    sw_raw = 18'h3FFFF;
    run(20, '1, p, ap, f, v);
    chk("t4_rise_pulses", WIDTH'(p), WIDTH'(1));
    chk("t4_rise_any", WIDTH'(ap), WIDTH'(1));
    chk("t4_rise_vec", v, 18'h3FFFF);
    sw_raw = '0;
    run(20, '1, p, ap, f, v);
    chk("t4_fall_pulses", WIDTH'(p), WIDTH'(1));
    chk("t4_fall_any", WIDTH'(ap), WIDTH'(1));
    chk("t4_fall_vec", v, 18'h3FFFF);
    chk("t4_fall_value", sw_debounced, '0);

    // 5: reset in the middle of counting, from a non-zero debounced state
    sw_raw = 18'h3FFFF;
    run(20, '1, p, ap, f, v);
    sw_raw = 18'h2AAAA;
    run(8, '1, p, ap, f, v);
    chk("t5_pre_value", sw_debounced, 18'h3FFFF);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_deb", sw_debounced, '0);
    chk("t5_rst_chg", sw_changed, '0);
    chk("t5_rst_any", WIDTH'(any_changed), '0);
    cycle();
    reset_n = 1'b1;
    run(20, '1, p, ap, f, v);
    chk("t5_latency", WIDTH'(((f - 1) >= 11) && ((f - 1) <= 14)), WIDTH'(1));
    chk("t5_pulses", WIDTH'(p), WIDTH'(1));
    chk("t5_any", WIDTH'(ap), WIDTH'(1));
    chk("t5_vec", v, 18'h2AAAA);
    chk("t5_value", sw_debounced, 18'h2AAAA);

    // Stable input: no further activity
    run(30, '1, p, ap, f, v);
    chk("stable_quiet", WIDTH'(p + ap), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
